// File: rtl/video_timing_pkg.sv
// Shared raster-timing definitions: counter width, stream-lock states and
// the sync-window compare used by every block that rides on the h/v counters.
package video_timing_pkg;

   localparam int CNT_W = 12;
   typedef logic [CNT_W-1:0] cnt_t;

   localparam logic ST_SEEK = 1'b0;
   localparam logic ST_RUN  = 1'b1;

   // Half-open window [start, stop) on a raster counter.
   function automatic logic in_window(input cnt_t cnt, input cnt_t start, input cnt_t stop);
      return (cnt >= start) && (cnt < stop);
   endfunction

endpackage

// File: rtl/video_timing_gen.sv
// Free-running h/v raster counters with the flags downstream blocks key off:
// active area, raster origin, last active pixel of a line and sync windows.
module video_timing_gen
   import video_timing_pkg::*;
#(
   parameter int H_ActiveSize = 1920,
   parameter int H_SyncStart  = 2008,
   parameter int H_SyncEnd    = 2052,
   parameter int H_FrameSize  = 2200,
   parameter int V_ActiveSize = 1080,
   parameter int V_SyncStart  = 1084,
   parameter int V_SyncEnd    = 1089,
   parameter int V_FrameSize  = 1125
) (
   input  logic I_pixel_clk,
   input  logic I_rst,
   output logic O_active,
   output logic O_origin,
   output logic O_eol,
   output logic O_hs_win,
   output logic O_vs_win
);

   cnt_t h_cnt;
   cnt_t v_cnt;

   // NOTE: sequential state is written with <= so every register samples the
   // pre-edge values; blocking assignments here would chain h_cnt into v_cnt.
   always_ff @(posedge I_pixel_clk) begin
      if (I_rst) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (h_cnt == cnt_t'(H_FrameSize - 1)) begin
         h_cnt <= '0;
         v_cnt <= (v_cnt == cnt_t'(V_FrameSize - 1)) ? '0 : v_cnt + 1'b1;
      end else begin
         h_cnt <= h_cnt + 1'b1;
      end
   end

   assign O_active = (h_cnt < cnt_t'(H_ActiveSize)) && (v_cnt < cnt_t'(V_ActiveSize));
   assign O_origin = (h_cnt == '0) && (v_cnt == '0);
   assign O_eol    = (h_cnt == cnt_t'(H_ActiveSize - 1));
   assign O_hs_win = in_window(h_cnt, cnt_t'(H_SyncStart), cnt_t'(H_SyncEnd));
   assign O_vs_win = in_window(v_cnt, cnt_t'(V_SyncStart), cnt_t'(V_SyncEnd));

endmodule

// File: rtl/hdmi_stream_to_rgb.sv
// Stream-to-RGB sink: free-running raster timing plus a SEEK/RUN lock that
// holds the stream SOF until the raster origin and drops lock on any slip.
module hdmi_stream_to_rgb
   import video_timing_pkg::*;
#(
   parameter int          H_ActiveSize = 1920,
   parameter int          H_SyncStart  = 2008,
   parameter int          H_SyncEnd    = 2052,
   parameter int          H_FrameSize  = 2200,
   parameter int          V_ActiveSize = 1080,
   parameter int          V_SyncStart  = 1084,
   parameter int          V_SyncEnd    = 1089,
   parameter int          V_FrameSize  = 1125,
   parameter logic        SYNC_POL     = 1'b1,
   parameter logic [23:0] BLANK_COLOR  = 24'h000000
) (
   input  logic        I_pixel_clk,
   input  logic        I_rst,
   input  logic        I_video_in_user,
   input  logic        I_video_in_valid,
   input  logic        I_video_in_last,
   input  logic [23:0] I_video_in_data,
   output logic        O_video_in_ready,
   output logic        O_video_out_de,
   output logic        O_video_out_hs,
   output logic        O_video_out_vs,
   output logic [23:0] O_video_out_data,
   output logic        O_locked,
   output logic        O_underflow,
   output logic        O_sync_err
);

   logic        active, origin, eol, hs_win, vs_win;
   logic        state, state_nxt;
   logic [23:0] data_nxt;
   logic        uf_nxt, se_nxt;

   video_timing_gen #(
      .H_ActiveSize(H_ActiveSize), .H_SyncStart(H_SyncStart),
      .H_SyncEnd(H_SyncEnd),       .H_FrameSize(H_FrameSize),
      .V_ActiveSize(V_ActiveSize), .V_SyncStart(V_SyncStart),
      .V_SyncEnd(V_SyncEnd),       .V_FrameSize(V_FrameSize)
   ) u_timing (
      .I_pixel_clk(I_pixel_clk),
      .I_rst(I_rst),
      .O_active(active),
      .O_origin(origin),
      .O_eol(eol),
      .O_hs_win(hs_win),
      .O_vs_win(vs_win)
   );

   // While seeking, everything but an early SOF is drained; SOF waits for origin.
   always_comb begin
      O_video_in_ready = 1'b0;
      if (!I_rst) begin
         if (state == ST_SEEK)
            O_video_in_ready = ~(I_video_in_valid & I_video_in_user) | origin;
         else
            O_video_in_ready = active;
      end
   end

   // NOTE: every output of this block gets a default first, so no path leaves
   // a variable unassigned and no latch is inferred.
   always_comb begin
      state_nxt = state;
      data_nxt  = '0;
      uf_nxt    = 1'b0;
      se_nxt    = 1'b0;
      if (active) begin
         data_nxt = BLANK_COLOR;
         if (state == ST_SEEK) begin
            if (I_video_in_valid && O_video_in_ready && I_video_in_user && origin) begin
               data_nxt  = I_video_in_data;
               state_nxt = ST_RUN;
            end
         end else if (!I_video_in_valid) begin
            uf_nxt    = 1'b1;
            state_nxt = ST_SEEK;
         end else begin
            data_nxt = I_video_in_data;
            if ((I_video_in_user != origin) || (I_video_in_last != eol)) begin
               se_nxt    = 1'b1;
               state_nxt = ST_SEEK;
            end
         end
      end
   end

   always_ff @(posedge I_pixel_clk) begin
      if (I_rst) begin
         state            <= ST_SEEK;
         O_video_out_de   <= 1'b0;
         O_video_out_hs   <= ~SYNC_POL;
         O_video_out_vs   <= ~SYNC_POL;
         O_video_out_data <= '0;
         O_locked         <= 1'b0;
         O_underflow      <= 1'b0;
         O_sync_err       <= 1'b0;
      end else begin
         state            <= state_nxt;
         O_video_out_de   <= active;
         O_video_out_hs   <= hs_win ? SYNC_POL : ~SYNC_POL;
         O_video_out_vs   <= vs_win ? SYNC_POL : ~SYNC_POL;
         O_video_out_data <= data_nxt;
         O_locked         <= (state_nxt == ST_RUN);
         O_underflow      <= uf_nxt;
         O_sync_err       <= se_nxt;
      end
   end

endmodule

// File: tb/tb_hdmi_stream_to_rgb.sv
// Self-checking bench for hdmi_stream_to_rgb on a tiny 14x8 raster, with a
// cycle-level reference model derived from the raster position and lock rules.
module tb_hdmi_stream_to_rgb;

   localparam int HA = 8, HSS = 10, HSE = 12, HF = 14;
   localparam int VA = 4, VSS = 5,  VSE = 6,  VF = 8;
   localparam int FRAME = HF * VF;
   localparam logic        POL   = 1'b1;
   localparam logic [23:0] BLANK = 24'h123456;

   typedef struct {
      logic        user;
      logic        last;
      logic [23:0] data;
      bit          gap;
   } px_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        user = 1'b0, valid = 1'b0, last = 1'b0;
   logic [23:0] din = '0;
   logic        rdy, de, hs, vs, locked, uf, se;
   logic [23:0] dout;

   px_t         src_q[$];
   logic [23:0] frm[$];
   logic [23:0] disp[$];

   int   total = 0, bad = 0;
   int   cyc = 0;
   bit   lock_m = 0, chk = 0;
   logic exp_de, exp_hs, exp_vs, exp_lock, exp_uf, exp_se;
   logic [23:0] exp_data;
   int   uf_cnt, se_cnt, acc_cnt, hs_cnt, vs_cnt, fall_cnt;
   bit   seen_de;
   logic first_de_lock, prev_lock = 1'b0;

   hdmi_stream_to_rgb #(
      .H_ActiveSize(HA), .H_SyncStart(HSS), .H_SyncEnd(HSE), .H_FrameSize(HF),
      .V_ActiveSize(VA), .V_SyncStart(VSS), .V_SyncEnd(VSE), .V_FrameSize(VF),
      .SYNC_POL(POL), .BLANK_COLOR(BLANK)
   ) dut (
      .I_pixel_clk(clk),
      .I_rst(rst),
      .I_video_in_user(user),
      .I_video_in_valid(valid),
      .I_video_in_last(last),
      .I_video_in_data(din),
      .O_video_in_ready(rdy),
      .O_video_out_de(de),
      .O_video_out_hs(hs),
      .O_video_out_vs(vs),
      .O_video_out_data(dout),
      .O_locked(locked),
      .O_underflow(uf),
      .O_sync_err(se)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // One pixel clock: check last edge's outputs, drive inputs, check ready,
   // then advance the reference model across the coming edge.
   task automatic step(input logic r);
      int   h, v;
      bit   act, org, eolm, xfer;
      logic exp_rdy;
      px_t  p;
      @(negedge clk);
      if (chk) begin
         total++; if (de !== exp_de) begin bad++; $display("FAIL de cyc=%0d got=%b want=%b", cyc, de, exp_de); end
         total++; if (hs !== exp_hs) begin bad++; $display("FAIL hs cyc=%0d got=%b want=%b", cyc, hs, exp_hs); end
         total++; if (vs !== exp_vs) begin bad++; $display("FAIL vs cyc=%0d got=%b want=%b", cyc, vs, exp_vs); end
         total++; if (dout !== exp_data) begin bad++; $display("FAIL data cyc=%0d got=%h want=%h", cyc, dout, exp_data); end
         total++; if (locked !== exp_lock) begin bad++; $display("FAIL locked cyc=%0d got=%b want=%b", cyc, locked, exp_lock); end
         total++; if (uf !== exp_uf) begin bad++; $display("FAIL underflow cyc=%0d got=%b want=%b", cyc, uf, exp_uf); end
         total++; if (se !== exp_se) begin bad++; $display("FAIL sync_err cyc=%0d got=%b want=%b", cyc, se, exp_se); end
         if (de === 1'b1) begin
            disp.push_back(dout);
            if (!seen_de) begin seen_de = 1; first_de_lock = locked; end
         end
         if (uf === 1'b1) uf_cnt++;
         if (se === 1'b1) se_cnt++;
         if (hs === POL) hs_cnt++;
         if (vs === POL) vs_cnt++;
         if (prev_lock === 1'b1 && locked === 1'b0) fall_cnt++;
         prev_lock = locked;
      end
      rst = r;
      if (src_q.size() > 0 && !src_q[0].gap) begin
         valid = 1'b1; user = src_q[0].user; last = src_q[0].last; din = src_q[0].data;
      end else begin
         valid = 1'b0; user = 1'($urandom_range(0, 1)); last = 1'($urandom_range(0, 1)); din = 24'($urandom);
      end
      #1;
      h = cyc % HF;
      v = (cyc / HF) % VF;
      act  = (h < HA) && (v < VA);
      org  = (h == 0) && (v == 0);
      eolm = (h == HA - 1);
      if (r)           exp_rdy = 1'b0;
      else if (!lock_m) exp_rdy = !(valid && user) || org;
      else             exp_rdy = act;
      total++; if (rdy !== exp_rdy) begin bad++; $display("FAIL ready cyc=%0d got=%b want=%b", cyc, rdy, exp_rdy); end
      if (rdy === 1'b1 && valid) acc_cnt++;
      xfer = valid && exp_rdy;
      exp_uf = 1'b0; exp_se = 1'b0;
      if (r) begin
         exp_de = 1'b0; exp_hs = ~POL; exp_vs = ~POL; exp_data = '0;
         lock_m = 0; cyc = 0;
      end else begin
         exp_de = act;
         exp_hs = (h >= HSS && h < HSE) ? POL : ~POL;
         exp_vs = (v >= VSS && v < VSE) ? POL : ~POL;
         if (!act) exp_data = '0;
         else if (!lock_m) begin
            exp_data = BLANK;
            if (xfer && user && org) begin exp_data = din; lock_m = 1; end
         end else if (!valid) begin
            exp_data = BLANK; exp_uf = 1'b1; lock_m = 0;
         end else begin
            exp_data = din;
            if ((user != org) || (last != eolm)) begin exp_se = 1'b1; lock_m = 0; end
         end
         cyc = (cyc + 1) % FRAME;
      end
      exp_lock = lock_m;
      if (xfer) src_q.delete(0);
      else if (src_q.size() > 0 && src_q[0].gap) begin
         p = src_q.pop_front(); p.gap = 0; src_q.push_front(p);
      end
      chk = 1;
   endtask

   task automatic clear_rec();
      uf_cnt = 0; se_cnt = 0; acc_cnt = 0; hs_cnt = 0; vs_cnt = 0; fall_cnt = 0;
      seen_de = 0; first_de_lock = 1'b0; disp.delete();
   endtask

   task automatic do_reset(input int n);
      src_q.delete(); frm.delete();
      repeat (n) step(1'b1);
      clear_rec();
   endtask

   task automatic push_frame(input bit rnd, input int gap_idx, input int short_idx, input logic [23:0] base);
      px_t p;
      for (int i = 0; i < 32; i++) begin
         p.user = (i == 0);
         p.last = (i % 8 == 7) || (i == short_idx);
         p.data = rnd ? 24'($urandom) : base + 24'(i);
         p.gap  = (i == gap_idx);
         src_q.push_back(p);
         frm.push_back(p.data);
      end
   endtask

   task automatic push_garbage(input int n);
      px_t p;
      for (int i = 0; i < n; i++) begin
         p.user = 1'b0; p.last = 1'($urandom_range(0, 1)); p.data = 24'($urandom); p.gap = 0;
         src_q.push_back(p);
      end
   endtask

   function automatic int diff_cnt(input int d_off, input int f_off, input int n);
      int e = 0;
      for (int i = 0; i < n; i++)
         if (d_off + i >= disp.size() || f_off + i >= frm.size() || disp[d_off + i] !== frm[f_off + i]) e++;
      return e;
   endfunction

   task automatic test_reset();
      do_reset(3);
      @(posedge clk); #1;
      total++; if (de !== 1'b0) begin bad++; $display("FAIL reset_de got=%b want=0", de); end
      total++; if (hs !== ~POL || vs !== ~POL) begin bad++; $display("FAIL reset_sync got=%b%b want=%b%b", hs, vs, ~POL, ~POL); end
      total++; if (dout !== 24'h0 || locked !== 1'b0) begin bad++; $display("FAIL reset_data_lock got=%h/%b want=0/0", dout, locked); end
      total++; if (rdy !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", rdy); end
   endtask

   task automatic test_clean_start();
      int d;
      do_reset(2);
      push_frame(0, -1, -1, 24'h000001);
      repeat (FRAME) step(1'b0);
      d = diff_cnt(0, 0, 32);
      total++; if (d != 0 || disp.size() != 32) begin bad++; $display("FAIL clean_pixels diffs=%0d shown=%0d want 0/32", d, disp.size()); end
      total++; if (first_de_lock !== 1'b1) begin bad++; $display("FAIL clean_lock_first_de got=%b want=1", first_de_lock); end
      total++; if (hs_cnt != 16 || vs_cnt != 14) begin bad++; $display("FAIL clean_sync_counts hs=%0d vs=%0d want 16/14", hs_cnt, vs_cnt); end
      total++; if (uf_cnt != 0 || se_cnt != 0) begin bad++; $display("FAIL clean_errors uf=%0d se=%0d want 0/0", uf_cnt, se_cnt); end
   endtask

   task automatic test_mid_frame();
      int d;
      do_reset(2);
      repeat (2 * HF) step(1'b0);
      push_frame(1, -1, -1, 24'h0);
      acc_cnt = 0;
      repeat (FRAME - 2 * HF) step(1'b0);
      total++; if (acc_cnt != 0) begin bad++; $display("FAIL mid_ready_early accepted=%0d want 0", acc_cnt); end
      disp.delete();
      repeat (FRAME) step(1'b0);
      d = diff_cnt(0, 0, 32);
      total++; if (d != 0 || disp.size() != 32) begin bad++; $display("FAIL mid_pixels diffs=%0d shown=%0d want 0/32", d, disp.size()); end
      total++; if (uf_cnt != 0 || se_cnt != 0) begin bad++; $display("FAIL mid_errors uf=%0d se=%0d want 0/0", uf_cnt, se_cnt); end
   endtask

   task automatic test_garbage();
      int d;
      do_reset(2);
      repeat (100) step(1'b0);
      push_garbage(5);
      push_frame(1, -1, -1, 24'h0);
      acc_cnt = 0;
      repeat (5) step(1'b0);
      total++; if (acc_cnt != 5) begin bad++; $display("FAIL garbage_drain accepted=%0d want 5", acc_cnt); end
      repeat (FRAME - 105) step(1'b0);
      disp.delete();
      repeat (60) step(1'b0);
      d = diff_cnt(0, 0, 32);
      total++; if (d != 0 || disp.size() != 32) begin bad++; $display("FAIL garbage_pixels diffs=%0d shown=%0d want 0/32", d, disp.size()); end
   endtask

   task automatic test_underflow();
      int d;
      do_reset(2);
      push_frame(1, 11, -1, 24'h0);
      push_frame(1, -1, -1, 24'h0);
      repeat (FRAME + 60) step(1'b0);
      total++; if (uf_cnt != 1 || se_cnt != 0) begin bad++; $display("FAIL uf_pulses uf=%0d se=%0d want 1/0", uf_cnt, se_cnt); end
      total++; if (disp.size() < 12 || disp[11] !== BLANK) begin bad++; $display("FAIL uf_blank_pixel got=%h want=%h", (disp.size() > 11) ? disp[11] : 24'hx, BLANK); end
      d = diff_cnt(0, 0, 11) + diff_cnt(32, 32, 32);
      total++; if (d != 0) begin bad++; $display("FAIL uf_pixels diffs=%0d want 0", d); end
      total++; if (fall_cnt != 1 || locked !== 1'b1) begin bad++; $display("FAIL uf_relock falls=%0d locked=%b want 1/1", fall_cnt, locked); end
   endtask

   task automatic test_short_line();
      int d;
      do_reset(2);
      push_frame(1, -1, 22, 24'h0);
      repeat (FRAME) step(1'b0);
      total++; if (se_cnt != 1 || uf_cnt != 0) begin bad++; $display("FAIL short_pulses se=%0d uf=%0d want 1/0", se_cnt, uf_cnt); end
      d = diff_cnt(0, 0, 23);
      total++; if (d != 0) begin bad++; $display("FAIL short_pixels diffs=%0d want 0", d); end
      total++; if (disp.size() < 24 || disp[23] !== BLANK) begin bad++; $display("FAIL short_drained got=%h want=%h", (disp.size() > 23) ? disp[23] : 24'hx, BLANK); end
      total++; if (locked !== 1'b0 || src_q.size() != 0) begin bad++; $display("FAIL short_seek locked=%b left=%0d want 0/0", locked, src_q.size()); end
   endtask

   task automatic test_reset_mid_line();
      int d;
      do_reset(2);
      push_frame(1, -1, -1, 24'h0);
      repeat (HF + 4) step(1'b0);
      src_q.delete(); frm.delete();
      push_frame(1, -1, -1, 24'h0);
      step(1'b1);
      @(posedge clk); #1;
      total++; if (de !== 1'b0 || hs !== ~POL || vs !== ~POL) begin bad++; $display("FAIL rst_mid_outputs de/hs/vs=%b%b%b want 0%b%b", de, hs, vs, ~POL, ~POL); end
      total++; if (rdy !== 1'b0) begin bad++; $display("FAIL rst_mid_ready got=%b want=0", rdy); end
      clear_rec();
      step(1'b0);
      step(1'b0);
      total++; if (de !== 1'b1 || locked !== 1'b1 || dout !== frm[0]) begin bad++; $display("FAIL rst_mid_restart de=%b lock=%b data=%h want 1/1/%h", de, locked, dout, frm[0]); end
      repeat (60) step(1'b0);
      d = diff_cnt(0, 0, 32);
      total++; if (d != 0) begin bad++; $display("FAIL rst_mid_pixels diffs=%0d want 0", d); end
   endtask

   task automatic test_random();
      do_reset(2);
      for (int f = 0; f < 6; f++) begin
         if ($urandom_range(0, 2) == 0) push_garbage(int'($urandom_range(1, 3)));
         push_frame(1, ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 31)) : -1,
                       ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 30)) : -1, 24'h0);
      end
      repeat (7 * FRAME) step(1'b0);
   endtask

   initial begin
      test_reset();
      test_clean_start();
      test_mid_frame();
      test_garbage();
      test_underflow();
      test_short_line();
      test_reset_mid_line();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
